// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the if_fetch_queue slice.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0040_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode handshake: fetch drives the head entry, decode drives id_ready.
interface if_fetch_queue_if;
  import cpu_pkg::*;

  logic              id_valid;
  logic              id_ready;
  logic [WORD_W-1:0] id_pc;
  logic [WORD_W-1:0] id_instr;
  logic [WORD_W-1:0] id_pc_plus4;

  modport master (output id_valid, id_pc, id_instr, id_pc_plus4, input id_ready);
  modport slave  (input id_valid, id_pc, id_instr, id_pc_plus4, output id_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head reads zero while empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: credit-based imem issue feeding a small (pc, instr) queue.
// Optional IF_FETCH_PERF_CNT_EN adds saturating stall / flush-drop counters.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int IMEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_in,
  output logic              pc_ena,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              flush,
  if_fetch_queue_if.master  id_bus
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_drop
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (IMEM_LAT != 1) begin : g_bad_imem_lat
    $error("if_fetch_queue supports only IMEM_LAT == 1");
  end

  logic [CW-1:0]     count;
  fetch_entry_t      head;
  logic              infl_q, infl_d;
  logic [WORD_W-1:0] infl_pc_q, infl_pc_d;
  logic              pop, issue, push;
  logic [CW:0]       credit;

  // Credit counts queued plus in-flight entries, so a returning read always finds space.
  always_comb begin
    pop       = id_bus.id_valid & id_bus.id_ready;
    credit    = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(pop);
    issue     = !flush && !rst && (credit < (CW+1)'(DEPTH));
    push      = infl_q && !flush && !rst;
    infl_d    = issue;
    infl_pc_d = issue ? pc_in : infl_pc_q;
    pc_ena    = !rst && (issue || flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ('{pc: infl_pc_q, instr: imem_rdata}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign imem_addr          = pc_in;
  assign id_bus.id_valid    = (count != '0);
  assign id_bus.id_pc       = head.pc;
  assign id_bus.id_instr    = head.instr;
  assign id_bus.id_pc_plus4 = (count != '0) ? pc_plus4(head.pc) : '0;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;
  logic [32:0] drop_sum;

  always_comb begin
    stall_d  = stall_q;
    drop_d   = drop_q;
    drop_sum = {1'b0, drop_q} + 33'(count) + 33'(infl_q) - 33'(pop);
    if (!flush && !issue && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush) begin
      drop_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign perf_stall_cyc  = stall_q;
  assign perf_flush_drop = drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: queue-based reference model, randomized traffic.
module tb_if_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] pc_in, imem_addr, imem_rdata;
  logic        pc_ena;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_drop;
`endif

  if_fetch_queue_if bus ();

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .IMEM_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_ena     (pc_ena),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .id_bus     (bus)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_flush_drop (perf_flush_drop)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: queued entries, at most one outstanding imem read, and the PC register.
  ent_t        mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] pc_reg;
  logic [31:0] rdata_next;
  logic [31:0] salt;
  bit          m_pop, m_issue;
  bit          cur_rst, cur_flush;
  logic [31:0] cur_target;
  logic [129:0] exp_vec;
  longint      m_stall, m_drop;
  int          checks, failures, cyc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [129:0] obs_vec();
    return {pc_ena, bus.id_valid, bus.id_pc, bus.id_instr, bus.id_pc_plus4, imem_addr};
  endfunction

  task automatic drive(input bit r, input bit f, input bit rdy, input logic [31:0] target);
    int occ;
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_p4;
    rst           = r;
    flush         = f;
    bus.id_ready  = rdy;
    pc_in         = pc_reg;
    imem_rdata    = rdata_next;
    cur_rst       = r;
    cur_flush     = f;
    cur_target    = target;
    m_pop   = (mq.size() > 0) && rdy;
    occ     = mq.size() + int'(m_infl) - int'(m_pop);
    m_issue = !f && !r && (occ < DEPTH);
    e_valid = mq.size() > 0;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_instr = e_valid ? mq[0].instr : 32'h0;
    e_p4    = e_valid ? mq[0].pc + 32'd4 : 32'h0;
    exp_vec = {(!r && (m_issue || f)), e_valid, e_pc, e_instr, e_p4, pc_reg};
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_rst) begin
      m_stall = 0;
      m_drop  = 0;
    end else begin
      if (!cur_flush && !m_issue && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (cur_flush) begin
        m_drop += mq.size() - int'(m_pop) + int'(m_infl);
        if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
      end
    end
    if (cur_rst) begin
      mq.delete();
      m_infl = 0;
      pc_reg = RESET_PC;
    end else if (cur_flush) begin
      mq.delete();
      m_infl = 0;
      pc_reg = cur_target;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_infl_pc, instr: imem_rdata});
      m_infl = m_issue;
      if (m_issue) begin
        m_infl_pc = pc_in;
        pc_reg    = pc_reg + 32'd4;
      end
    end
    rdata_next = instr_of(pc_in);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      checks++;
      if ({pc_ena, bus.id_valid, bus.id_pc} !== 34'h0) begin
        failures++;
        $display("[TB] FAIL reset_state cycle=%0d got=%h expected=0", cyc, {pc_ena, bus.id_valid, bus.id_pc});
      end
      advance();
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("[TB] FAIL stream cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      if (i == 2) begin
        checks++;
        if ({bus.id_valid, bus.id_pc, bus.id_pc_plus4} !== {1'b1, 32'h0040_0000, 32'h0040_0004}) begin
          failures++;
          $display("[TB] FAIL first_entry got=%h/%h expected=00400000/00400004", bus.id_pc, bus.id_pc_plus4);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, (i >= 5), 32'h0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("[TB] FAIL stall cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      if (i == 4) begin
        checks++;
        if ({pc_ena, bus.id_valid} !== 2'b01) begin
          failures++;
          $display("[TB] FAIL stall_hold got=pc_ena:%b valid:%b expected=pc_ena:0 valid:1", pc_ena, bus.id_valid);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (obs_vec() !== exp_vec || pc_ena !== 1'b1) begin
        failures++;
        $display("[TB] FAIL back_to_back cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_vec() !== exp_vec) begin
      failures++;
      $display("[TB] FAIL flush_setup cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
    end
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i == 0), 1'b1, 32'h0040_0100);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("[TB] FAIL flush cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      if (i == 1) begin
        checks++;
        if ({bus.id_valid, pc_in} !== {1'b0, 32'h0040_0100}) begin
          failures++;
          $display("[TB] FAIL flush_empty got=valid:%b pc_in:%h expected=valid:0 pc_in:00400100", bus.id_valid, pc_in);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 14; i++) begin
      drive((i < 2), 1'b0, 1'b1, 32'h0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("[TB] FAIL reset_mid cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      if (i == 1) begin
        checks++;
        if ({pc_ena, bus.id_valid} !== 2'b00) begin
          failures++;
          $display("[TB] FAIL reset_mid_state got=pc_ena:%b valid:%b expected=0/0", pc_ena, bus.id_valid);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, f, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(99) < 2);
      f   = ($urandom_range(99) < 6);
      rdy = ($urandom_range(99) < 70);
      tgt = {$urandom_range(32'h00FF_FFFF), 2'b00};
      drive(r, f, rdy, tgt);
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec);
      end
      advance();
    end
  endtask

`ifdef IF_FETCH_PERF_CNT_EN
  task automatic test_perf_counters();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({perf_stall_cyc, perf_flush_drop} !== {m_stall[31:0], m_drop[31:0]}) begin
      failures++;
      $display("[TB] FAIL perf got=%0d/%0d expected=%0d/%0d", perf_stall_cyc, perf_flush_drop, m_stall, m_drop);
    end
    advance();
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    salt       = $urandom;
    m_infl     = 0;
    m_infl_pc  = '0;
    m_stall    = 0;
    m_drop     = 0;
    pc_reg     = RESET_PC;
    rdata_next = '0;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef IF_FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
